axi4_reader: RTL and testbench

AXI4_READER -- requirements
Module: axi4_reader

---
 rtl/axi4_reader.sv | 188 ++++++++++++++++++
 tb/tb_axi4_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_reader.sv
// -----------------------------------------------------------------------------
// axi4_reader
//
// Streams one video frame out of DDR over an AXI4 read channel. Each frame is
// fetched as FRAME_BYTES/512 back-to-back INCR bursts of 64 x 64-bit beats.
// Only one burst is ever outstanding. The next address is issued only while
// the downstream pixel FIFO reports room for a whole burst. Read data is
// forwarded combinationally to that FIFO.
//
// Ports
//   clk_100Mhz, rst       sole clock, synchronous active-high reset
//   frame_start           level request; a rising edge starts a frame
//   FRAME_BASE_ADDR       frame base, captured on the accepted edge
//   fifo_prog_full        downstream FIFO cannot take another burst
//   AR*                   AXI4 read-address channel (fixed burst shape)
//   R*                    AXI4 read-data channel
//   pix_data / pix_valid  FIFO write data / write enable
//   reader_busy           high whenever a frame is in progress
//   reader_done           one-cycle pulse on the final beat of a frame
//   frame_skip            one-cycle pulse when a start edge arrives mid-frame
//   resp_err              sticky: bad RRESP or misplaced/missing RLAST seen
// -----------------------------------------------------------------------------
module axi4_reader #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int FRAME_BYTES    = 153600
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [31:0]               FRAME_BASE_ADDR,
  input  logic                      fifo_prog_full,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic                      RLAST,
  input  logic [1:0]                RRESP,
  output logic [AXI_DATA_WIDTH-1:0] pix_data,
  output logic                      pix_valid,
  output logic                      reader_busy,
  output logic                      reader_done,
  output logic                      frame_skip,
  output logic                      resp_err
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    ADDR_SEND  = 2'd2,
    DATA_RECV  = 2'd3
  } state_e;

  localparam logic [31:0] BURST_BYTES = 32'd512;
  localparam logic [31:0] LAST_OFFSET = 32'(FRAME_BYTES - 512);

  state_e                    state_q, state_d;
  logic                      frame_start_d1_q;
  logic [31:0]               base_q, base_d;
  logic [31:0]               offset_q, offset_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                      arvalid_q, arvalid_d;
  logic [6:0]                beat_cnt_q, beat_cnt_d;
  logic                      resp_err_q, resp_err_d;

  logic frame_edge;
  logic rready;
  logic beat_acc;
  logic last_beat;
  logic frame_end;

  assign frame_edge = frame_start && !frame_start_d1_q;
  assign rready     = (state_q == DATA_RECV);
  assign beat_acc   = RVALID && rready;
  assign last_beat  = beat_acc && (beat_cnt_q == 7'd63);
  assign frame_end  = last_beat && (offset_q == LAST_OFFSET);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      state_q          <= IDLE;
      // Reset high means a level already high at release is not an edge.
      frame_start_d1_q <= 1'b1;
      base_q           <= '0;
      offset_q         <= '0;
      araddr_q         <= '0;
      arvalid_q        <= 1'b0;
      beat_cnt_q       <= '0;
      resp_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_start_d1_q <= frame_start;
      base_q           <= base_d;
      offset_q         <= offset_d;
      araddr_q         <= araddr_d;
      arvalid_q        <= arvalid_d;
      beat_cnt_q       <= beat_cnt_d;
      resp_err_q       <= resp_err_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    offset_d   = offset_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    beat_cnt_d = beat_cnt_q;
    resp_err_d = resp_err_q;

    // RLAST must appear on the 64th beat and nowhere else. The burst length
    // is still governed by our own count, never by RLAST.
    if (beat_acc && ((RRESP != 2'b00) || (RLAST != (beat_cnt_q == 7'd63)))) begin
      resp_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          base_d   = FRAME_BASE_ADDR;
          offset_d = '0;
          state_d  = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        // Only throttling point: once the address is out, the burst is
        // drained regardless of fifo_prog_full.
        if (!fifo_prog_full) begin
          araddr_d  = AXI_ADDR_WIDTH'(base_q + offset_q);
          arvalid_d = 1'b1;
          state_d   = ADDR_SEND;
        end
      end
      ADDR_SEND: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = DATA_RECV;
        end
      end
      DATA_RECV: begin
        if (last_beat) begin
          beat_cnt_d = '0;
          if (offset_q == LAST_OFFSET) begin
            state_d = IDLE;
          end else begin
            offset_d = offset_q + BURST_BYTES;
            state_d  = WAIT_SPACE;
          end
        end else if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ARADDR  = araddr_q;
  assign ARVALID = arvalid_q;
  assign ARLEN   = 8'd63;
  assign ARSIZE  = 3'b011;
  assign ARBURST = 2'b01;
  assign ARCACHE = 4'b0011;
  assign ARPROT  = 3'b010;
  assign RREADY  = rready;

  assign pix_data    = RDATA;
  assign pix_valid   = beat_acc;
  assign reader_busy = (state_q != IDLE);
  assign resp_err    = resp_err_q;

  // Both pulses are combinational so they coincide with the cycle that causes
  // them. reader_done is high on the final beat, while the state is still
  // DATA_RECV, so a start edge in that same cycle is reported as a skip.
  // Gating with rst keeps both low while reset is held.
  assign reader_done = !rst && frame_end;
  assign frame_skip  = !rst && frame_edge && (state_q != IDLE);

endmodule

// File: tb/tb_axi4_reader.sv
// -----------------------------------------------------------------------------
// tb_axi4_reader
//
// Self-checking bench for axi4_reader. The bench acts as the AXI slave memory.
// Expected burst addresses are queued when a frame is requested. Expected beat
// data is queued when each address is accepted. Both queues are popped and
// compared as the DUT produces handshakes and pixel writes.
// -----------------------------------------------------------------------------
module tb_axi4_reader;

  localparam int FRAME_BYTES = 153600;
  localparam int BURSTS      = FRAME_BYTES / 512;
  localparam int BEATS       = 64;
  localparam logic [63:0] SENTINEL = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk_100Mhz;
  logic        rst;
  logic        frame_start;
  logic [31:0] FRAME_BASE_ADDR;
  logic        fifo_prog_full;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [63:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic        RLAST;
  logic [1:0]  RRESP;
  logic [63:0] pix_data;
  logic        pix_valid;
  logic        reader_busy;
  logic        reader_done;
  logic        frame_skip;
  logic        resp_err;

  axi4_reader #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (64),
    .FRAME_BYTES    (FRAME_BYTES)
  ) dut (
    .clk_100Mhz      (clk_100Mhz),
    .rst             (rst),
    .frame_start     (frame_start),
    .FRAME_BASE_ADDR (FRAME_BASE_ADDR),
    .fifo_prog_full  (fifo_prog_full),
    .ARADDR          (ARADDR),
    .ARVALID         (ARVALID),
    .ARREADY         (ARREADY),
    .ARLEN           (ARLEN),
    .ARSIZE          (ARSIZE),
    .ARBURST         (ARBURST),
    .ARCACHE         (ARCACHE),
    .ARPROT          (ARPROT),
    .RDATA           (RDATA),
    .RVALID          (RVALID),
    .RREADY          (RREADY),
    .RLAST           (RLAST),
    .RRESP           (RRESP),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .reader_busy     (reader_busy),
    .reader_done     (reader_done),
    .frame_skip      (frame_skip),
    .resp_err        (resp_err)
  );

  initial begin
    clk_100Mhz = 1'b0;
    forever #5 clk_100Mhz = ~clk_100Mhz;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] addr, input int beat);
    return {addr, 32'(beat) ^ 32'hC0DE_0000};
  endfunction

  // Stimulus controls, owned by the main sequence.
  int unsigned gap_pct;
  int          ar_delay;
  logic [31:0] err_addr;
  logic [31:0] rlast_drop_addr;
  logic        pf_chk;
  int          req_seq;
  logic [31:0] req_base;

  // Scoreboard state, owned by the monitor.
  logic [31:0] exp_ar_q[$];
  logic [63:0] exp_data_q[$];
  int          ar_cnt, pix_cnt, done_cnt, skip_cnt, stall, seen_seq;
  logic [31:0] stall_addr, ar_hs_addr;
  logic        ar_hs, beat_taken, dphase;

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, i.e. the values the next rising edge
  // will act on.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [63:0] exp;
    ar_cnt = 0; pix_cnt = 0; done_cnt = 0; skip_cnt = 0; stall = 0; seen_seq = 0;
    stall_addr = '0; ar_hs_addr = '0; ar_hs = 1'b0; beat_taken = 1'b0; dphase = 1'b0;
    forever begin
      @(negedge clk_100Mhz);
      ar_hs      = 1'b0;
      beat_taken = 1'b0;
      if (rst) begin
        exp_ar_q.delete();
        exp_data_q.delete();
        dphase   = 1'b0;
        stall    = 0;
        seen_seq = req_seq;
      end else begin
        if (req_seq != seen_seq) begin
          for (int k = 0; k < BURSTS; k++) exp_ar_q.push_back(req_base + 32'(k * 512));
          seen_seq = req_seq;
        end
        check("pix_valid", 64'(pix_valid), 64'(RVALID && RREADY));
        check("rready", 64'(RREADY), 64'(dphase));
        if (pf_chk) check("arvalid_throttled", 64'(ARVALID), 64'(0));
        if (ARVALID && !ARREADY) begin
          if (stall > 0) check("araddr_stable", 64'(ARADDR), 64'(stall_addr));
          stall_addr = ARADDR;
          stall++;
        end
        if (ARVALID && ARREADY) begin
          exp = (exp_ar_q.size() > 0) ? 64'(exp_ar_q.pop_front()) : SENTINEL;
          check("araddr", 64'(ARADDR), exp);
          check("ar_stall_cycles", 64'(stall), 64'(ar_delay));
          check("ar_outstanding", 64'(exp_data_q.size()), 64'(0));
          for (int b = 0; b < BEATS; b++) exp_data_q.push_back(beat_data(exp[31:0], b));
          ar_hs      = 1'b1;
          ar_hs_addr = ARADDR;
          ar_cnt++;
          stall  = 0;
          dphase = 1'b1;
        end
        if (pix_valid) begin
          exp = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : SENTINEL;
          check("pix_data", pix_data, exp);
          pix_cnt++;
          beat_taken = 1'b1;
          if (exp_data_q.size() == 0) dphase = 1'b0;
        end
        if (reader_done) done_cnt++;
        if (frame_skip)  skip_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // AXI slave: updates its drives 1 ns after each rising edge.
  // ---------------------------------------------------------------------------
  initial begin : slave
    logic [31:0] rd_q[$];
    int beat_idx;
    int ar_wait;
    ARREADY = 1'b1; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
    beat_idx = 0; ar_wait = 0;
    forever begin
      @(posedge clk_100Mhz);
      #1;
      if (rst) begin
        rd_q.delete();
        beat_idx = 0;
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      end else begin
        if (ar_hs) rd_q.push_back(ar_hs_addr);
        if (beat_taken) begin
          RVALID = 1'b0;
          beat_idx++;
          if (beat_idx == BEATS) begin
            void'(rd_q.pop_front());
            beat_idx = 0;
          end
        end
        // Once RVALID is up it stays up, with the same beat, until it is taken.
        if (!RVALID && rd_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
          RVALID = 1'b1;
          RDATA  = beat_data(rd_q[0], beat_idx);
          RLAST  = (beat_idx == BEATS - 1) && (rd_q[0] != rlast_drop_addr);
          RRESP  = (rd_q[0] == err_addr && beat_idx == 17) ? 2'b10 : 2'b00;
        end
      end
      if (ar_delay == 0) begin
        ARREADY = 1'b1;
        ar_wait = 0;
      end else if (ARVALID) begin
        ar_wait++;
        ARREADY = (ar_wait > ar_delay);
      end else begin
        ARREADY = 1'b0;
        ar_wait = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int ar0, pix0, done0, skip0;

  function automatic int metric(input int sel);
    case (sel)
      0:       return ar_cnt - ar0;
      1:       return pix_cnt - pix0;
      default: return done_cnt - done0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int target, input int budget);
    int n = 0;
    while (metric(sel) < target && n < budget) begin
      @(posedge clk_100Mhz);
      #2;
      n++;
    end
    check(tag, 64'(metric(sel) >= target), 64'(1));
  endtask

  task automatic start_frame(input logic [31:0] base);
    @(posedge clk_100Mhz);
    #2;
    ar0 = ar_cnt; pix0 = pix_cnt; done0 = done_cnt; skip0 = skip_cnt;
    FRAME_BASE_ADDR = base;
    req_base        = base;
    frame_start     = 1'b1;
    req_seq++;
    repeat (2) @(posedge clk_100Mhz);
    #2;
    frame_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(ARVALID), 64'(0));
    check({tag, "_araddr"}, 64'(ARADDR), 64'(0));
    check({tag, "_rready"}, 64'(RREADY), 64'(0));
    check({tag, "_pix_valid"}, 64'(pix_valid), 64'(0));
    check({tag, "_busy"}, 64'(reader_busy), 64'(0));
    check({tag, "_done"}, 64'(reader_done), 64'(0));
    check({tag, "_skip"}, 64'(frame_skip), 64'(0));
    check({tag, "_resp_err"}, 64'(resp_err), 64'(0));
  endtask

  task automatic check_frame_totals(input string tag, input int skips, input logic err);
    check({tag, "_ar_count"}, 64'(ar_cnt - ar0), 64'(BURSTS));
    check({tag, "_pix_count"}, 64'(pix_cnt - pix0), 64'(BURSTS * BEATS));
    check({tag, "_done_count"}, 64'(done_cnt - done0), 64'(1));
    check({tag, "_skip_count"}, 64'(skip_cnt - skip0), 64'(skips));
    check({tag, "_ar_left"}, 64'(exp_ar_q.size()), 64'(0));
    check({tag, "_busy"}, 64'(reader_busy), 64'(0));
    check({tag, "_resp_err"}, 64'(resp_err), 64'(err));
  endtask

  initial begin : main
    n_checks = 0; n_pass = 0;
    rst = 1'b1; frame_start = 1'b0; FRAME_BASE_ADDR = '0; fifo_prog_full = 1'b0;
    gap_pct = 0; ar_delay = 0; err_addr = '1; rlast_drop_addr = '1; pf_chk = 1'b0;
    req_seq = 0; req_base = '0; ar0 = 0; pix0 = 0; done0 = 0; skip0 = 0;

    repeat (3) @(posedge clk_100Mhz);
    @(negedge clk_100Mhz);
    check_reset_outputs("por");
    check("arlen", 64'(ARLEN), 64'(63));
    check("arsize", 64'(ARSIZE), 64'(3));
    check("arburst", 64'(ARBURST), 64'(1));
    check("arcache", 64'(ARCACHE), 64'(3));
    check("arprot", 64'(ARPROT), 64'(2));
    @(posedge clk_100Mhz);
    #2;
    rst = 1'b0;

    // Frame 1: unthrottled full frame.
    start_frame(32'h1000_0000);
    check("f1_busy", 64'(reader_busy), 64'(1));
    wait_for("f1_done_timeout", 2, 1, 30000);
    repeat (5) @(posedge clk_100Mhz);
    check("f1_last_araddr", 64'(ar_hs_addr), 64'(32'h1002_5600));
    check_frame_totals("f1", 0, 1'b0);

    // Frame 2: RVALID gaps, FIFO throttling, slow ARREADY, bad RRESP,
    // and a start edge in the middle of the frame.
    gap_pct  = 30;
    err_addr = 32'h2000_0000 + 32'(10 * 512);
    start_frame(32'h2000_0000);
    wait_for("f2_ar6_timeout", 0, 6, 5000);
    fifo_prog_full = 1'b1;
    wait_for("f2_drain_under_pf", 1, 6 * BEATS, 5000);
    @(posedge clk_100Mhz);
    #2;
    pf_chk = 1'b1;
    repeat (50) @(posedge clk_100Mhz);
    #2;
    pf_chk         = 1'b0;
    fifo_prog_full = 1'b0;
    check("f2_pf_ar_count", 64'(ar_cnt - ar0), 64'(6));
    wait_for("f2_ar7_timeout", 0, 7, 200);
    check("f2_burst6_addr", 64'(ar_hs_addr), 64'(32'h2000_0C00));
    ar_delay = 7;
    wait_for("f2_ar8_timeout", 0, 8, 500);
    ar_delay = 0;
    check("f2_resp_err_clean", 64'(resp_err), 64'(0));
    wait_for("f2_ar12_timeout", 0, 12, 2000);
    check("f2_resp_err_set", 64'(resp_err), 64'(1));
    wait_for("f2_ar101_timeout", 0, 101, 20000);
    wait_for("f2_b100_beats", 1, 100 * BEATS + 10, 500);
    @(posedge clk_100Mhz);
    #2;
    FRAME_BASE_ADDR = 32'h3000_0000;
    frame_start     = 1'b1;
    @(negedge clk_100Mhz);
    check("f2_skip_pulse", 64'(frame_skip), 64'(1));
    check("f2_skip_busy", 64'(reader_busy), 64'(1));
    @(negedge clk_100Mhz);
    check("f2_skip_one_cycle", 64'(frame_skip), 64'(0));
    @(posedge clk_100Mhz);
    #2;
    frame_start     = 1'b0;
    FRAME_BASE_ADDR = 32'h2000_0000;
    wait_for("f2_done_timeout", 2, 1, 40000);
    repeat (5) @(posedge clk_100Mhz);
    check("f2_last_araddr", 64'(ar_hs_addr), 64'(32'h2002_5600));
    check_frame_totals("f2", 1, 1'b1);

    // Frame 3: reset in the middle of a burst, with frame_start held high
    // across the reset release.
    gap_pct = 0;
    start_frame(32'h4000_0000);
    wait_for("f3_beat30_timeout", 1, 30, 500);
    @(posedge clk_100Mhz);
    #2;
    rst         = 1'b1;
    frame_start = 1'b1;
    @(posedge clk_100Mhz);
    @(negedge clk_100Mhz);
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk_100Mhz);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100Mhz);
      check("rst_release_no_edge", 64'(reader_busy), 64'(0));
    end
    @(posedge clk_100Mhz);
    #2;
    frame_start = 1'b0;

    // Frame 4: restart from offset 0, with RLAST missing on the first burst.
    rlast_drop_addr = 32'h5000_0000;
    start_frame(32'h5000_0000);
    wait_for("f4_ar1_timeout", 0, 1, 200);
    check("f4_first_araddr", 64'(ar_hs_addr), 64'(32'h5000_0000));
    check("f4_resp_err_clean", 64'(resp_err), 64'(0));
    wait_for("f4_ar2_timeout", 0, 2, 500);
    check("f4_rlast_err", 64'(resp_err), 64'(1));
    check("f4_second_araddr", 64'(ar_hs_addr), 64'(32'h5000_0200));
    check("f4_pix_count", 64'(pix_cnt - pix0), 64'(BEATS));
    @(posedge clk_100Mhz);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk_100Mhz);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
